// File: rtl/tl_a_arb2.sv
// Two-to-one TileLink-UL A/D arbiter: round-robin A with burst lock, D steered
// by a port tag above the source ID, per-port in-flight throttling.
module tl_a_arb2 #(
  parameter int SRC_W        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in0_a_valid,
  output logic              in0_a_ready,
  input  logic [2:0]        in0_a_opcode,
  input  logic [2:0]        in0_a_param,
  input  logic [2:0]        in0_a_size,
  input  logic [SRC_W-1:0]  in0_a_source,
  input  logic [31:0]       in0_a_address,
  input  logic [3:0]        in0_a_mask,
  input  logic [31:0]       in0_a_data,
  input  logic              in1_a_valid,
  output logic              in1_a_ready,
  input  logic [2:0]        in1_a_opcode,
  input  logic [2:0]        in1_a_param,
  input  logic [2:0]        in1_a_size,
  input  logic [SRC_W-1:0]  in1_a_source,
  input  logic [31:0]       in1_a_address,
  input  logic [3:0]        in1_a_mask,
  input  logic [31:0]       in1_a_data,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [2:0]        out_a_opcode,
  output logic [2:0]        out_a_param,
  output logic [2:0]        out_a_size,
  output logic [SRC_W:0]    out_a_source,
  output logic [31:0]       out_a_address,
  output logic [3:0]        out_a_mask,
  output logic [31:0]       out_a_data,
  input  logic              out_d_valid,
  output logic              out_d_ready,
  input  logic [2:0]        out_d_opcode,
  input  logic [1:0]        out_d_param,
  input  logic [2:0]        out_d_size,
  input  logic [SRC_W:0]    out_d_source,
  input  logic              out_d_sink,
  input  logic              out_d_denied,
  input  logic [31:0]       out_d_data,
  input  logic              out_d_corrupt,
  output logic              in0_d_valid,
  input  logic              in0_d_ready,
  output logic [2:0]        in0_d_opcode,
  output logic [1:0]        in0_d_param,
  output logic [2:0]        in0_d_size,
  output logic [SRC_W-1:0]  in0_d_source,
  output logic              in0_d_sink,
  output logic              in0_d_denied,
  output logic [31:0]       in0_d_data,
  output logic              in0_d_corrupt,
  output logic              in1_d_valid,
  input  logic              in1_d_ready,
  output logic [2:0]        in1_d_opcode,
  output logic [1:0]        in1_d_param,
  output logic [2:0]        in1_d_size,
  output logic [SRC_W-1:0]  in1_d_source,
  output logic              in1_d_sink,
  output logic              in1_d_denied,
  output logic [31:0]       in1_d_data,
  output logic              in1_d_corrupt,
  output logic              err_unexpected_d
);
  localparam logic [3:0] MAXC = 4'(MAX_INFLIGHT);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       param;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic [31:0]      address;
    logic [3:0]       mask;
    logic [31:0]      data;
  } aReq_t;

  // Beats-1 for a message of 2^size bytes on a 4-byte bus, clamped to 4 bits.
  function automatic logic [3:0] beatsM1(input logic multi, input logic [2:0] sz);
    logic [3:0] r;
    r = 4'd0;
    if (multi) begin
      case (sz)
        3'd3:    r = 4'd1;
        3'd4:    r = 4'd3;
        3'd5:    r = 4'd7;
        3'd6,
        3'd7:    r = 4'd15;
        default: r = 4'd0;
      endcase
    end
    return r;
  endfunction

  aReq_t [1:0]      aReq;
  logic  [1:0]      aValid, elig, aRdy, inc, dec, unexp;
  logic  [1:0][3:0] cnt;
  logic             prio, lock, lockPort, grant, aFire, dFire, dLast, dPort, err;
  logic  [3:0]      aBeat, dBeat, aLen, dLen;
  aReq_t            gReq;

  assign aReq[0] = '{in0_a_opcode, in0_a_param, in0_a_size, in0_a_source,
                     in0_a_address, in0_a_mask, in0_a_data};
  assign aReq[1] = '{in1_a_opcode, in1_a_param, in1_a_size, in1_a_source,
                     in1_a_address, in1_a_mask, in1_a_data};
  assign aValid  = {in1_a_valid, in0_a_valid};

  assign grant = lock ? lockPort : ((elig[0] & elig[1]) ? prio : elig[1]);
  assign gReq  = aReq[grant];
  assign aLen  = beatsM1(gReq.opcode <= 3'd3, gReq.size);
  assign dLen  = beatsM1(out_d_opcode == 3'd1, out_d_size);
  assign dPort = out_d_source[SRC_W];

  assign out_a_valid   = ~reset & elig[grant];
  assign aFire         = out_a_valid & out_a_ready;
  assign out_a_opcode  = gReq.opcode;
  assign out_a_param   = gReq.param;
  assign out_a_size    = gReq.size;
  assign out_a_source  = {grant, gReq.source};
  assign out_a_address = gReq.address;
  assign out_a_mask    = gReq.mask;
  assign out_a_data    = gReq.data;
  assign in0_a_ready   = aRdy[0];
  assign in1_a_ready   = aRdy[1];

  assign out_d_ready = ~reset & (dPort ? in1_d_ready : in0_d_ready);
  assign dFire       = out_d_valid & out_d_ready;
  // Last beat: either a single-beat message or the final count of a burst.
  assign dLast       = dFire & ((dBeat == 4'd0) ? (dLen == 4'd0) : (dBeat == 4'd1));
  assign in0_d_valid = ~reset & out_d_valid & ~dPort;
  assign in1_d_valid = ~reset & out_d_valid & dPort;
  assign {in0_d_opcode, in0_d_param, in0_d_size, in0_d_sink, in0_d_denied, in0_d_data, in0_d_corrupt} =
         {out_d_opcode, out_d_param, out_d_size, out_d_sink, out_d_denied, out_d_data, out_d_corrupt};
  assign {in1_d_opcode, in1_d_param, in1_d_size, in1_d_sink, in1_d_denied, in1_d_data, in1_d_corrupt} =
         {out_d_opcode, out_d_param, out_d_size, out_d_sink, out_d_denied, out_d_data, out_d_corrupt};
  assign in0_d_source = out_d_source[SRC_W-1:0];
  assign in1_d_source = out_d_source[SRC_W-1:0];
  assign err_unexpected_d = err;

  // Per-port eligibility and in-flight counter.
  for (genvar i = 0; i < 2; i++) begin : g_port
    assign elig[i]  = aValid[i] & (lock ? (lockPort == 1'(i)) : (cnt[i] < MAXC));
    assign aRdy[i]  = ~reset & out_a_ready & elig[i] & (grant == 1'(i));
    assign inc[i]   = aFire & ~lock & (grant == 1'(i));
    assign dec[i]   = dLast & (dPort == 1'(i));
    assign unexp[i] = dec[i] & (cnt[i] == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
      if (reset)                 cnt[i] <= 4'd0;
      else if (inc[i] & ~dec[i]) begin
        if (cnt[i] < MAXC)       cnt[i] <= cnt[i] + 4'd1;
      end else if (dec[i] & ~inc[i]) begin
        if (cnt[i] != 4'd0)      cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio     <= 1'b0;
      lock     <= 1'b0;
      lockPort <= 1'b0;
      aBeat    <= 4'd0;
      dBeat    <= 4'd0;
      err      <= 1'b0;
    end else begin
      if (aFire) begin
        if (!lock) begin
          if (aLen != 4'd0) begin
            lock     <= 1'b1;
            lockPort <= grant;
            aBeat    <= aLen;
          end else begin
            prio     <= ~grant;
          end
        end else begin
          aBeat <= aBeat - 4'd1;
          if (aBeat == 4'd1) begin
            lock <= 1'b0;
            prio <= ~grant;
          end
        end
      end
      if (dFire) dBeat <= (dBeat == 4'd0) ? dLen : dBeat - 4'd1;
      if (|unexp) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tl_a_arb2.sv
// Directed-vector bench for tl_a_arb2 (SRC_W=4, MAX_INFLIGHT=4).
module tb_tl_a_arb2;
  logic        clock, reset;
  logic        in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
  logic [2:0]  in0_a_opcode, in0_a_param, in0_a_size, in1_a_opcode, in1_a_param, in1_a_size;
  logic [3:0]  in0_a_source, in1_a_source, in0_a_mask, in1_a_mask;
  logic [31:0] in0_a_address, in0_a_data, in1_a_address, in1_a_data;
  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode, out_a_param, out_a_size;
  logic [4:0]  out_a_source;
  logic [31:0] out_a_address, out_a_data;
  logic [3:0]  out_a_mask;
  logic        out_d_valid, out_d_ready, out_d_sink, out_d_denied, out_d_corrupt;
  logic [2:0]  out_d_opcode, out_d_size;
  logic [1:0]  out_d_param;
  logic [4:0]  out_d_source;
  logic [31:0] out_d_data;
  logic        in0_d_valid, in0_d_ready, in0_d_sink, in0_d_denied, in0_d_corrupt;
  logic        in1_d_valid, in1_d_ready, in1_d_sink, in1_d_denied, in1_d_corrupt;
  logic [2:0]  in0_d_opcode, in0_d_size, in1_d_opcode, in1_d_size;
  logic [1:0]  in0_d_param, in1_d_param;
  logic [3:0]  in0_d_source, in1_d_source;
  logic [31:0] in0_d_data, in1_d_data;
  logic        err_unexpected_d;

  int nVec = 0;
  int nMis = 0;

  tl_a_arb2 #(.SRC_W(4), .MAX_INFLIGHT(4)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
    .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
    .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_data(out_d_data),
    .out_d_corrupt(out_d_corrupt),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_param(in0_d_param), .in0_d_size(in0_d_size), .in0_d_source(in0_d_source),
    .in0_d_sink(in0_d_sink), .in0_d_denied(in0_d_denied), .in0_d_data(in0_d_data),
    .in0_d_corrupt(in0_d_corrupt),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_param(in1_d_param), .in1_d_size(in1_d_size), .in1_d_source(in1_d_source),
    .in1_d_sink(in1_d_sink), .in1_d_denied(in1_d_denied), .in1_d_data(in1_d_data),
    .in1_d_corrupt(in1_d_corrupt),
    .err_unexpected_d(err_unexpected_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic setA0(input logic v, input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
    in0_a_valid = v; in0_a_opcode = op; in0_a_size = sz; in0_a_source = src;
    in0_a_param = 3'd0; in0_a_address = 32'h0000_1000; in0_a_mask = 4'hf; in0_a_data = 32'haaaa_0000;
  endtask

  task automatic setA1(input logic v, input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
    in1_a_valid = v; in1_a_opcode = op; in1_a_size = sz; in1_a_source = src;
    in1_a_param = 3'd0; in1_a_address = 32'h0000_2000; in1_a_mask = 4'hf; in1_a_data = 32'hbbbb_0000;
  endtask

  task automatic setD(input logic v, input logic [2:0] op, input logic [2:0] sz, input logic [4:0] src,
                      input logic r0, input logic r1);
    out_d_valid = v; out_d_opcode = op; out_d_size = sz; out_d_source = src;
    out_d_param = 2'd0; out_d_sink = 1'b0; out_d_denied = 1'b0; out_d_data = 32'hd00d_0000;
    out_d_corrupt = 1'b0; in0_d_ready = r0; in1_d_ready = r1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    setA0(0, 3'd4, 3'd2, 4'd0); setA1(0, 3'd4, 3'd2, 4'd0);
    setD(0, 3'd0, 3'd2, 5'd0, 0, 0);
    out_a_ready = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state: valids driven high must not leak through.
    reset = 1'b1; out_a_ready = 1'b1;
    setA0(1, 3'd4, 3'd2, 4'd1); setA1(1, 3'd4, 3'd2, 4'd2);
    setD(1, 3'd1, 3'd2, 5'h10, 1, 1);
    #2;
    chk("rst_out_a_valid", 32'(out_a_valid), 0);
    chk("rst_a_ready", 32'({in1_a_ready, in0_a_ready}), 0);
    chk("rst_d", 32'({out_d_ready, in1_d_valid, in0_d_valid}), 0);
    chk("rst_err", 32'(err_unexpected_d), 0);

    // Round-robin on single-beat Gets.
    doReset;
    setA0(1, 3'd4, 3'd2, 4'd3); setA1(1, 3'd4, 3'd2, 4'd7);
    for (int k = 0; k < 4; k++) begin
      #2;
      if (k % 2 == 0) begin
        chk("rr_src0", 32'(out_a_source), 32'h03);
        chk("rr_rdy0", 32'({in1_a_ready, in0_a_ready}), 32'b01);
        chk("rr_addr0", out_a_address, 32'h1000);
      end else begin
        chk("rr_src1", 32'(out_a_source), 32'h17);
        chk("rr_rdy1", 32'({in1_a_ready, in0_a_ready}), 32'b10);
        chk("rr_addr1", out_a_address, 32'h2000);
      end
      tick;
    end

    // 4-beat PutFull on port 0 locks out port 1.
    doReset;
    setA0(1, 3'd0, 3'd4, 4'd1); setA1(1, 3'd4, 3'd2, 4'd2);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("burst_rdy", 32'({in1_a_ready, in0_a_ready}), 32'b01);
      tick;
    end
    #2;
    chk("burst_after_rdy", 32'({in1_a_ready, in0_a_ready}), 32'b10);
    chk("burst_after_src", 32'(out_a_source), 32'h12);
    tick;

    // In-flight throttle on port 0.
    doReset;
    setA0(1, 3'd4, 3'd2, 4'd1);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("thr_fill", 32'(in0_a_ready), 1);
      tick;
    end
    #2;
    chk("thr_block_rdy", 32'(in0_a_ready), 0);
    chk("thr_block_vld", 32'(out_a_valid), 0);
    setA1(1, 3'd4, 3'd2, 4'd6);
    #2;
    chk("thr_p1_rdy", 32'(in1_a_ready), 1);
    chk("thr_p1_src", 32'(out_a_source), 32'h16);
    tick;
    setA1(0, 3'd4, 3'd2, 4'd6);
    setD(1, 3'd1, 3'd2, 5'h01, 1, 0);
    #2;
    chk("thr_d_vld", 32'({in1_d_valid, in0_d_valid}), 32'b01);
    chk("thr_d_rdy", 32'(out_d_ready), 1);
    chk("thr_still_blocked", 32'(in0_a_ready), 0);
    tick;
    setD(0, 3'd0, 3'd2, 5'h0, 0, 0);
    #2;
    chk("thr_resume", 32'(in0_a_ready), 1);
    tick;

    // 2-beat AccessAckData to port 1 decrements cnt1 only once.
    doReset;
    setA1(1, 3'd4, 3'd2, 4'd5);
    #2;
    chk("d2_get_rdy", 32'(in1_a_ready), 1);
    tick;
    setA1(0, 3'd4, 3'd2, 4'd5);
    setD(1, 3'd1, 3'd3, 5'h15, 0, 0);
    #2;
    chk("d2_vld", 32'({in1_d_valid, in0_d_valid}), 32'b10);
    chk("d2_src", 32'(in1_d_source), 5);
    chk("d2_rdy_lo", 32'(out_d_ready), 0);
    tick;
    in1_d_ready = 1'b1;
    #2;
    chk("d2_rdy_hi", 32'(out_d_ready), 1);
    tick;
    #2;
    chk("d2_beat2_vld", 32'(in1_d_valid), 1);
    tick;
    setD(0, 3'd0, 3'd2, 5'h0, 0, 0);
    #2;
    chk("d2_no_err", 32'(err_unexpected_d), 0);
    setD(1, 3'd0, 3'd2, 5'h15, 0, 1);
    tick;
    setD(0, 3'd0, 3'd2, 5'h0, 0, 0);
    #2;
    chk("d2_extra_err", 32'(err_unexpected_d), 1);

    // Unexpected D to port 0: sticky error, counter stays at 0.
    doReset;
    setD(1, 3'd1, 3'd2, 5'h03, 1, 0);
    #2;
    chk("unx_vld", 32'(in0_d_valid), 1);
    chk("unx_err_pre", 32'(err_unexpected_d), 0);
    tick;
    setD(0, 3'd0, 3'd2, 5'h0, 0, 0);
    #2;
    chk("unx_err_set", 32'(err_unexpected_d), 1);
    tick; tick;
    chk("unx_err_sticky", 32'(err_unexpected_d), 1);
    setA0(1, 3'd4, 3'd2, 4'd1);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("unx_cnt_fill", 32'(in0_a_ready), 1);
      tick;
    end
    #2;
    chk("unx_cnt_block", 32'(in0_a_ready), 0);

    // Reset during beat 2 of a port-1 burst.
    doReset;
    setA1(1, 3'd0, 3'd4, 4'd9);
    #2;
    chk("mid_b1", 32'(in1_a_ready), 1);
    tick;
    #2;
    chk("mid_b2", 32'(in1_a_ready), 1);
    reset = 1'b1;
    setA0(1, 3'd4, 3'd2, 4'd2); setA1(1, 3'd4, 3'd2, 4'd9);
    setD(1, 3'd1, 3'd2, 5'h00, 1, 1);
    #1;
    chk("mid_rst_avld", 32'(out_a_valid), 0);
    chk("mid_rst_ardy", 32'({in1_a_ready, in0_a_ready}), 0);
    chk("mid_rst_d", 32'({out_d_ready, in1_d_valid, in0_d_valid}), 0);
    tick; tick;
    reset = 1'b0;
    setD(0, 3'd0, 3'd2, 5'h0, 0, 0);
    #2;
    chk("post_rst_rdy", 32'({in1_a_ready, in0_a_ready}), 32'b01);
    chk("post_rst_src", 32'(out_a_source), 32'h02);
    tick;
    #2;
    chk("post_rst_next", 32'({in1_a_ready, in0_a_ready}), 32'b10);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/tl_a_arb2.md
# tl_a_arb2

Two-to-one TileLink-UL arbiter that lets two requesters share one downstream A/D channel pair, such as a single A-source/D-sink buffer block. A is multiplexed round-robin, and multi-beat write bursts are locked. D responses are steered back by a port tag appended above the upstream source ID. Per-port in-flight counters throttle each requester and flag responses that no request accounts for.

## Interface
Parameters:
- SRC_W, 4, upstream source-ID width; downstream source width is SRC_W+1.
- MAX_INFLIGHT, 4, maximum open messages per port (1..15).

Ports (i = 0,1; A payload = opcode[2:0], param[2:0], size[2:0], source[SRC_W-1:0], address[31:0], mask[3:0], data[31:0]):
- clock  in  1  sole clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high.
- in{i}_a_valid  in  1  requester i A valid.
- in{i}_a_ready  out  1  requester i A ready.
- in{i}_a_*  in  payload  requester i A fields.
- out_a_valid  out  1  downstream A valid.
- out_a_ready  in  1  downstream A ready.
- out_a_*  out  payload  muxed A fields; out_a_source = {port, in{port}_a_source}.
- out_d_valid  in  1  downstream D valid.
- out_d_ready  out  1  downstream D ready.
- out_d_*  in  opcode[2:0], param[1:0], size[2:0], source[SRC_W:0], sink, denied, data[31:0], corrupt.
- in{i}_d_valid  out  1  steered D valid.
- in{i}_d_ready  in  1  requester i D ready.
- in{i}_d_*  out  as out_d_*, but source is [SRC_W-1:0].
- err_unexpected_d  out  1  sticky; set by a D beat routed to a port whose counter is 0.

## Operation
- Beats per A message: opcodes 0, 1, 2, 3 with size>2 give 1<<(size-2); all others give 1. Beats per D message: opcode 1 with size>2 gives 1<<(size-2); all others give 1.
- State:
  - prio (1 bit): port that wins the next tie.
  - lock (1 bit) and lock_port: a burst is in progress on that port.
  - a_beat[3:0] and d_beat[3:0]: remaining beats.
  - cnt0 and cnt1 (4 bits each): in-flight messages per port.
  - err (1 bit).
- Eligibility: port i is eligible when in{i}_a_valid=1 and either (lock=1 and lock_port=i) or (lock=0 and cnt_i<MAX_INFLIGHT).
- Grant, combinational:
  - lock=1 → lock_port.
  - Otherwise, if only one port is eligible → that port.
  - Otherwise, if both are eligible → prio.
- Datapath: out_a_valid = the granted port's eligibility. in{g}_a_ready = out_a_ready & eligible_g, where g is the granted port. The other port's a_ready = 0.
- On each A fire:
  - First beat of a message (lock=0): cnt_g is incremented.
  - If beats>1: lock=1, lock_port=g, a_beat=beats-1.
  - Later beats: a_beat is decremented. At the final beat, lock=0 and prio=~g.
  - A single-beat message sets prio=~g on its only beat.
- D routing:
  - p = out_d_source[SRC_W].
  - in{p}_d_valid = out_d_valid. The other port's d_valid = 0.
  - out_d_ready = in{p}_d_ready.
  - All D payload is fanned out to both ports; in{i}_d_source drops the MSB.
- On each D fire:
  - d_beat tracks the multi-beat message.
  - On the last beat, cnt_p is decremented.
  - If cnt_p=0 at that point, the counter holds at 0 and err is set.
- Simultaneous increment and decrement of the same counter → value unchanged.
- Counters saturate at MAX_INFLIGHT; they never wrap.

## Timing
- A and D paths are zero-latency and combinational. No ready→ready or valid→valid combinational loop is introduced beyond the straight passthrough.
- The arbitration decision changes only between messages. Grant is stable for every beat of a locked burst, even if the other port raises valid.
- While reset=1:
  - All valid and ready outputs are forced to 0.
  - prio=0, lock=0, a_beat=0, d_beat=0, cnt0=cnt1=0, err=0.
- Reset mid-burst abandons the burst; after reset, arbitration restarts with port 0 priority.
- Counter updates take effect in the cycle after the fire. A port at cnt=MAX_INFLIGHT−1 that fires is blocked from the next cycle onward.
- A stall with out_a_ready=0 holds the grant and all state.

## Test plan
- Both ports send single-beat Gets continuously, with out_a_ready=1 → grants alternate 0,1,0,1. out_a_source MSB matches the port. Each in{i}_a_ready pulses every other cycle.
- Port 0 sends PutFull size=4 (4 beats) while port 1 is valid → four consecutive port-0 beats, then port 1 is granted. in1_a_ready=0 throughout the burst.
- MAX_INFLIGHT=4, port 0 issues 4 Gets with no D → fifth Get stalls (in0_a_ready=0) while port 1 still proceeds. One AccessAckData with source MSB=0 → port 0 resumes the following cycle.
- D AccessAckData size=3 (2 beats) with source {1,4'h5} → in1_d_valid asserts for 2 beats, in1_d_source=5, in0_d_valid=0. out_d_ready follows in1_d_ready. cnt1 decrements once.
- D beat to port 0 with cnt0=0 → err_unexpected_d=1 the next cycle and it stays 1. cnt0 remains 0.
- Assert reset during beat 2 of a 4-beat port-1 burst → all valid and ready outputs are 0 during reset. Afterward, port 0 wins the first tie, and no leftover lock holds port 1.
